// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed little-endian byte stream to 32-bit word writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] word_cnt
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE} state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CSUM;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t      state, state_nxt;
    logic [15:0] len;
    logic [23:0] asm_q;
    logic [1:0]  byte_idx;
    logic        accept;
    logic        last_word;

    assign accept    = byte_valid && byte_ready;
    // 17-bit compare so word_cnt+1 never wraps against N=65535
    assign last_word = ({1'b0, word_cnt} + 17'd1) >= {1'b0, len};
    assign cpu_hold  = (state != DONE);
    assign load_done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LEN0;
            end
            LEN0: begin
                byte_ready = 1'b1;
                if (accept) state_nxt = LEN1;
            end
            LEN1: begin
                byte_ready = 1'b1;
                if (accept) begin
                    if ({byte_data, len[7:0]} == 16'd0) state_nxt = END_STATE;
                    else                                state_nxt = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (accept && byte_idx == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                imem_we   = 1'b1;
                state_nxt = last_word ? END_STATE : DATA;
            end
            CSUM: begin
                byte_ready = 1'b1;
                if (accept) state_nxt = DONE;
            end
            DONE: begin
                if (start) state_nxt = LEN0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len        <= '0;
            asm_q      <= '0;
            byte_idx   <= '0;
            word_cnt   <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len      <= '0;
                        asm_q    <= '0;
                        byte_idx <= '0;
                        word_cnt <= '0;
                    end
                end
                LEN0: if (accept) len[7:0]  <= byte_data;
                LEN1: if (accept) len[15:8] <= byte_data;
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_q[7:0]   <= byte_data;
                            2'd1: asm_q[15:8]  <= byte_data;
                            2'd2: asm_q[23:16] <= byte_data;
                            default: begin
                                // Address/data captured on entry to WRITE and held afterwards
                                imem_wdata <= {byte_data, asm_q};
                                imem_addr  <= {14'd0, word_cnt, 2'b00};
                            end
                        endcase
                    end
                end
                WRITE: word_cnt <= word_cnt + 16'd1;
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum     <= '0;
            load_err <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        csum     <= '0;
                        load_err <= 1'b0;
                    end
                end
                DATA: if (accept) csum <= csum ^ byte_data;
                CSUM: if (accept) load_err <= (byte_data != csum);
                default: ;
            endcase
        end
    end
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader; expected writes are queued as stimulus is driven.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];
    logic prev_we = 1'b0;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (imem_we) begin
            check("we_single", {31'd0, prev_we}, 32'd0);
            if (sb_q.size() == 0) begin
                check("we_expected", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("addr", imem_addr, e[63:32]);
                check("wdata", imem_wdata, e[31:0]);
            end
        end
        prev_we = imem_we;
    end

    task automatic send_byte(input logic [7:0] b, output int waits);
        byte_valid = 1'b1;
        byte_data  = b;
        waits      = 0;
        while (waits < 50) begin
            @(negedge clk);
            if (byte_ready) break;
            waits++;
        end
        if (waits >= 50) check("byte_timeout", 32'(waits), 32'd0);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bs[$], input bit toggle);
        int w;
        foreach (bs[i]) begin
            send_byte(bs[i], w);
            if (toggle) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_hold", {31'd0, cpu_hold}, 32'd1);
        check("start_done", {31'd0, load_done}, 32'd0);
        check("start_err", {31'd0, load_err}, 32'd0);
        check("start_cnt", {16'd0, word_cnt}, 32'd0);
        check("start_ready", {31'd0, byte_ready}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!load_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, load_done}, 32'd1);
    endtask

    task automatic load_a(input bit toggle);
        logic [7:0] s[$];
        s = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        sb_q.push_back({32'h0, 32'h00A00513});
        sb_q.push_back({32'h4, 32'h00100593});
        do_start();
        send_seq(s, toggle);
`ifdef IMEM_LOADER_CHECKSUM_EN
        s = {8'h30};
        send_seq(s, toggle);
`endif
        wait_done();
        check("a_cnt", {16'd0, word_cnt}, 32'd2);
        check("a_hold", {31'd0, cpu_hold}, 32'd0);
        check("a_err", {31'd0, load_err}, 32'd0);
        check("a_sb", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] s[$];
        int w;

        // reset with start asserted
        rst_n = 1'b0; start = 1'b1; byte_valid = 1'b0; byte_data = '0;
        #1;
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        check("rst_cnt", {16'd0, word_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'd0, byte_ready}, 32'd0);
        check("idle_hold", {31'd0, cpu_hold}, 32'd1);

        // main load, valid held and toggled
        load_a(1'b0);
        load_a(1'b1);

        // N = 0
        do_start();
        s = {8'h00, 8'h00};
        send_seq(s, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("n0_csum_ready", {31'd0, byte_ready}, 32'd1);
        check("n0_csum_done", {31'd0, load_done}, 32'd0);
        s = {8'h00};
        send_seq(s, 1'b0);
        wait_done();
        check("n0_err", {31'd0, load_err}, 32'd0);
`else
        check("n0_done", {31'd0, load_done}, 32'd1);
`endif
        check("n0_cnt", {16'd0, word_cnt}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // checksum good then bad
        sb_q.push_back({32'h0, 32'h12345678});
        do_start();
        s = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_seq(s, 1'b0);
        wait_done();
        check("csum_ok", {31'd0, load_err}, 32'd0);
        sb_q.push_back({32'h0, 32'h12345678});
        do_start();
        s = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        send_seq(s, 1'b0);
        wait_done();
        check("csum_bad", {31'd0, load_err}, 32'd1);
        check("csum_cnt", {16'd0, word_cnt}, 32'd1);
`endif

        // asynchronous reset after 3rd data byte of word 1
        do_start();
        s = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0};
        send_seq(s, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, byte_ready}, 32'd0);
        check("arst_we", {31'd0, imem_we}, 32'd0);
        check("arst_addr", imem_addr, 32'd0);
        check("arst_wdata", imem_wdata, 32'd0);
        check("arst_hold", {31'd0, cpu_hold}, 32'd1);
        check("arst_done", {31'd0, load_done}, 32'd0);
        check("arst_cnt", {16'd0, word_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_idle", {31'd0, byte_ready}, 32'd0);
        load_a(1'b0);

        // start ignored in DATA; byte presented during WRITE waits one cycle
        sb_q.push_back({32'h0, 32'h00A00513});
        sb_q.push_back({32'h4, 32'h00100593});
        do_start();
        s = {8'h02, 8'h00, 8'h13};
        send_seq(s, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("data_start_ready", {31'd0, byte_ready}, 32'd1);
        check("data_start_cnt", {16'd0, word_cnt}, 32'd0);
        s = {8'h05, 8'hA0, 8'h00};
        send_seq(s, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'h93;
        @(negedge clk);
        check("write_ready", {31'd0, byte_ready}, 32'd0);
        check("write_we", {31'd0, imem_we}, 32'd1);
        send_byte(8'h93, w);
        check("write_wait", 32'(w), 32'd0);
        check("write_cnt", {16'd0, word_cnt}, 32'd1);
        s = {8'h05, 8'h10, 8'h00};
        send_seq(s, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        s = {8'h30};
        send_seq(s, 1'b0);
`endif
        wait_done();
        check("ws_cnt", {16'd0, word_cnt}, 32'd2);
        check("sb_left", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
